// File: rtl/audio_mix_pkg.sv
// Shared types, constants and sample-format helpers for the audio mix sequencer.
// Holds the slot order, FSM states, source conversions and the 16-bit saturator.
package audio_mix_pkg;

    typedef enum logic [2:0] {
        S_L_A1,
        S_L_A2,
        S_L_SP,
        S_L_YM,
        S_R_A1,
        S_R_A2,
        S_R_SP,
        S_R_YM
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SAT
    } state_e;

    localparam logic [3:0]         GAIN_UNITY = 4'd8;
    localparam int                 GAIN_SHIFT = 3;
    localparam logic signed [15:0] S16_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] S16_MIN    = 16'sh8000;

    // Offset-binary to two's complement: midscale of the unsigned source maps to 0.
    function automatic logic signed [15:0] u8_to_s16(input logic [7:0] x);
        return {~x[7], x[6:0], 8'h00};
    endfunction

    function automatic logic signed [15:0] u16_to_s16(input logic [15:0] s);
        return {~s[15], s[14:0]};
    endfunction

    // Returns {clip, value}; clip is set whenever the input is outside the s16 range.
    function automatic logic [16:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return {1'b1, S16_MAX};
        end else if (v < -32'sd32768) begin
            return {1'b1, S16_MIN};
        end else begin
            return {1'b0, v[15:0]};
        end
    endfunction

endpackage

// File: rtl/audio_mix_sequencer_if.sv
// Source/sample bundle between the Williams-2 sound sources, the mixer and the audio sink.
// sample_valid is a one-cycle strobe with no ready: the sink must take audio_l/audio_r that cycle; they hold until the next strobe.
interface audio_mix_sequencer_if;

    logic [7:0]                   audio_1;
    logic [7:0]                   audio_2;
    logic [15:0]                  speech;
    logic signed [15:0]           ym2151_left;
    logic signed [15:0]           ym2151_right;
    logic [19:0]                  gains;
    logic                         mute;
    logic signed [15:0]           audio_l;
    logic signed [15:0]           audio_r;
    logic                         sample_valid;
    logic                         clip_l;
    logic                         clip_r;
    logic                         busy;
    audio_mix_pkg::state_e        state_dbg;

    modport master (
        output audio_1, audio_2, speech, ym2151_left, ym2151_right, gains, mute,
        input  audio_l, audio_r, sample_valid, clip_l, clip_r, busy, state_dbg
    );

    modport slave (
        input  audio_1, audio_2, speech, ym2151_left, ym2151_right, gains, mute,
        output audio_l, audio_r, sample_valid, clip_l, clip_r, busy, state_dbg
    );

endinterface

// File: rtl/audio_mac_sat.sv
// Shared slot datapath: signed 16-bit sample times unsigned 4-bit gain, sign-extended
// to accumulator width. Purely combinational; the sequencer owns all registers.
module audio_mac_sat #(
    parameter int ACC_W = 24
) (
    input  logic signed [15:0]      sample_i,
    input  logic [3:0]              gain_i,
    output logic signed [ACC_W-1:0] product_o
);

    logic signed [20:0] product;

    assign product   = $signed(21'(sample_i)) * $signed(21'({1'b0, gain_i}));
    assign product_o = ACC_W'(product);

endmodule

// File: rtl/audio_mix_sequencer.sv
// Sample-rate mixer: on each divider tick, snapshot all sources and run eight
// gain-weighted MAC slots through one shared multiplier, then saturate to s16.
module audio_mix_sequencer
    import audio_mix_pkg::*;
#(
    parameter int DIV   = 250,
    parameter int ACC_W = 24
) (
    input logic                  clock_12,
    input logic                  reset,
    audio_mix_sequencer_if.slave mix
);

    logic [11:0]             div_q, div_d;
    logic                    tick;
    state_e                  state_q, state_d;
    slot_e                   slot_q, slot_d;
    logic signed [15:0]      a1_q, a1_d, a2_q, a2_d, sp_q, sp_d;
    logic signed [15:0]      yml_q, yml_d, ymr_q, ymr_d;
    logic [19:0]             gains_q, gains_d;
    logic                    mute_q, mute_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [15:0]      out_l_q, out_l_d, out_r_q, out_r_d;
    logic                    clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                    valid_q, valid_d;

    logic signed [15:0]      mac_sample;
    logic [3:0]              mac_gain;
    logic signed [ACC_W-1:0] mac_product;
    logic [16:0]             sat_l, sat_r;

    assign tick  = (div_q == 12'(DIV - 1));
    assign div_d = tick ? 12'd0 : div_q + 12'd1;

    always_comb begin
        mac_sample = a1_q;
        mac_gain   = gains_q[3:0];
        case (slot_q)
            S_L_A1, S_R_A1: begin mac_sample = a1_q;  mac_gain = gains_q[3:0];   end
            S_L_A2, S_R_A2: begin mac_sample = a2_q;  mac_gain = gains_q[7:4];   end
            S_L_SP, S_R_SP: begin mac_sample = sp_q;  mac_gain = gains_q[11:8];  end
            S_L_YM:         begin mac_sample = yml_q; mac_gain = gains_q[15:12]; end
            S_R_YM:         begin mac_sample = ymr_q; mac_gain = gains_q[19:16]; end
            default: ;
        endcase
    end

    audio_mac_sat #(.ACC_W(ACC_W)) u_mac (
        .sample_i  (mac_sample),
        .gain_i    (mac_gain),
        .product_o (mac_product)
    );

    // Drop the unity-gain scaling, floor toward -inf, then clamp to s16.
    assign sat_l = sat16(32'(acc_l_q >>> GAIN_SHIFT));
    assign sat_r = sat16(32'(acc_r_q >>> GAIN_SHIFT));

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        sp_d     = sp_q;
        yml_d    = yml_q;
        ymr_d    = ymr_q;
        gains_d  = gains_q;
        mute_d   = mute_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;
        clip_l_d = clip_l_q;
        clip_r_d = clip_r_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    a1_d    = u8_to_s16(mix.audio_1);
                    a2_d    = u8_to_s16(mix.audio_2);
                    sp_d    = u16_to_s16(mix.speech);
                    yml_d   = mix.ym2151_left;
                    ymr_d   = mix.ym2151_right;
                    gains_d = mix.gains;
                    mute_d  = mix.mute;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    slot_d  = S_L_A1;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // Slots 0..3 feed the left side, 4..7 the right.
                if (slot_q[2]) acc_r_d = acc_r_q + mac_product;
                else           acc_l_d = acc_l_q + mac_product;
                if (slot_q == S_R_YM) state_d = ST_SAT;
                else                  slot_d  = slot_e'(slot_q + 3'd1);
            end
            ST_SAT: begin
                out_l_d  = mute_q ? 16'sd0 : sat_l[15:0];
                out_r_d  = mute_q ? 16'sd0 : sat_r[15:0];
                clip_l_d = mute_q ? 1'b0 : sat_l[16];
                clip_r_d = mute_q ? 1'b0 : sat_r[16];
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_12) begin
        if (reset) begin
            div_q    <= '0;
            state_q  <= ST_IDLE;
            slot_q   <= S_L_A1;
            a1_q     <= '0;
            a2_q     <= '0;
            sp_q     <= '0;
            yml_q    <= '0;
            ymr_q    <= '0;
            gains_q  <= '0;
            mute_q   <= 1'b0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            slot_q   <= slot_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            sp_q     <= sp_d;
            yml_q    <= yml_d;
            ymr_q    <= ymr_d;
            gains_q  <= gains_d;
            mute_q   <= mute_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
            valid_q  <= valid_d;
        end
    end

    // A tick can only be honoured in IDLE; DIV >= 12 keeps it from landing mid-sequence.
    always_ff @(posedge clock_12) begin
        if (!reset) begin
            assert (!(tick && (state_q != ST_IDLE)));
        end
    end

    assign mix.audio_l      = out_l_q;
    assign mix.audio_r      = out_r_q;
    assign mix.clip_l       = clip_l_q;
    assign mix.clip_r       = clip_r_q;
    assign mix.sample_valid = valid_q;
    assign mix.busy         = (state_q != ST_IDLE);
    assign mix.state_dbg    = state_q;

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Bench for audio_mix_sequencer: sources are driven between ticks, the expected
// sample is queued from an integer model and checked when sample_valid pulses.
module tb_audio_mix_sequencer;
    import audio_mix_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   since = 0;
    logic [33:0] exp_q[$];

    audio_mix_sequencer_if mix();

    audio_mix_sequencer #(.DIV(250), .ACC_W(24)) dut (
        .clock_12 (clk),
        .reset    (rst),
        .mix      (mix)
    );

    always #5 clk = ~clk;

    // Cycle index since the last cycle in which reset was sampled high.
    always @(posedge clk) since <= rst ? 0 : since + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] model(input logic [7:0] a1, input logic [7:0] a2,
                                          input logic [15:0] sp, input logic signed [15:0] yl,
                                          input logic signed [15:0] yr, input logic [19:0] g,
                                          input logic m);
        int sa1, sa2, ssp, l, r;
        logic cl, cr;
        sa1 = (int'(a1) - 128) * 256;
        sa2 = (int'(a2) - 128) * 256;
        ssp = int'(sp) - 32768;
        l = sa1 * int'(g[3:0]) + sa2 * int'(g[7:4]) + ssp * int'(g[11:8]) + int'(yl) * int'(g[15:12]);
        r = sa1 * int'(g[3:0]) + sa2 * int'(g[7:4]) + ssp * int'(g[11:8]) + int'(yr) * int'(g[19:16]);
        l = l >>> 3;
        r = r >>> 3;
        cl = 1'b0;
        cr = 1'b0;
        if (l > 32767)  begin l = 32767;  cl = 1'b1; end
        if (l < -32768) begin l = -32768; cl = 1'b1; end
        if (r > 32767)  begin r = 32767;  cr = 1'b1; end
        if (r < -32768) begin r = -32768; cr = 1'b1; end
        if (m) begin l = 0; r = 0; cl = 1'b0; cr = 1'b0; end
        return {cl, cr, l[15:0], r[15:0]};
    endfunction

    task automatic drive(input logic [7:0] a1, input logic [7:0] a2, input logic [15:0] sp,
                         input logic signed [15:0] yl, input logic signed [15:0] yr,
                         input logic [19:0] g, input logic m);
        mix.audio_1 = a1;
        mix.audio_2 = a2;
        mix.speech = sp;
        mix.ym2151_left = yl;
        mix.ym2151_right = yr;
        mix.gains = g;
        mix.mute = m;
        exp_q.push_back(model(a1, a2, sp, yl, yr, g, m));
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mix.sample_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mix.busy) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit got;
        logic [33:0] e;
        drive(8'h80, 8'h80, 16'h8000, 16'sh0, 16'sh0, {5{GAIN_UNITY}}, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({mix.audio_l, mix.audio_r, mix.sample_valid, mix.clip_l, mix.clip_r, mix.busy} !== 36'h0
            || mix.state_dbg !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got l=%h r=%h v=%b cl=%b cr=%b busy=%b st=%0d want all 0 / IDLE",
                     mix.audio_l, mix.audio_r, mix.sample_valid, mix.clip_l, mix.clip_r, mix.busy, mix.state_dbg);
        end
        rst = 1'b0;
        wait_valid(400, got);
        total++;
        if (!got || since != 259) begin
            bad++;
            $display("FAIL first_valid_cycle: got=%0b at %0d want cycle 259", got, since);
        end
        e = exp_q.pop_front();
        total++;
        if ({mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
            bad++;
            $display("FAIL first_sample: got %h want %h", {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
        drive(8'h80, 8'h80, 16'h8000, 16'sh0, 16'sh0, {5{GAIN_UNITY}}, 1'b0);
        wait_valid(300, got);
        e = exp_q.pop_front();
        total++;
        if (!got || since != 509) begin
            bad++;
            $display("FAIL second_valid_cycle: got=%0b at %0d want cycle 509", got, since);
        end
    endtask

    task automatic test_unity_mix;
        bit got;
        int t_busy;
        logic [33:0] e;
        drive(8'hFF, 8'h80, 16'h8000, 16'sh0, 16'sh0, 20'h88888, 1'b0);
        wait_busy(300, got);
        t_busy = since;
        wait_valid(30, got);
        total++;
        if (!got || since - t_busy != 9 || mix.busy !== 1'b0) begin
            bad++;
            $display("FAIL unity_latency: got=%0b busy->valid=%0d busy=%b want 9 and busy 0", got, since - t_busy, mix.busy);
        end
        e = exp_q.pop_front();
        total++;
        if ({mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e || mix.audio_l !== 16'h7F00) begin
            bad++;
            $display("FAIL unity_sample: got %h want %h", {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
        repeat (3) @(negedge clk);
        total++;
        if (mix.sample_valid !== 1'b0 || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
            bad++;
            $display("FAIL unity_hold: got v=%b %h want v=0 %h", mix.sample_valid,
                     {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
    endtask

    task automatic test_clip;
        bit got;
        logic [33:0] e;
        drive(8'hFF, 8'h00, 16'hFFFF, 16'sh8000, 16'sh7FFF, 20'hFF000, 1'b0);
        wait_valid(300, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e || e !== {2'b11, 16'h8000, 16'h7FFF}) begin
            bad++;
            $display("FAIL clip_sample: got=%0b %h want %h", got, {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
    endtask

    task automatic test_snapshot;
        bit got;
        logic [33:0] e;
        drive(8'h80, 8'h80, 16'h8000, 16'sh1000, 16'sh1234, 20'h04000, 1'b0);
        wait_busy(300, got);
        repeat (2) @(negedge clk);
        mix.ym2151_left = 16'sh7FFF;
        mix.gains = 20'hFFFFF;
        mix.mute = 1'b1;
        wait_valid(30, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e || mix.audio_l !== 16'h0800) begin
            bad++;
            $display("FAIL snapshot_sample: got=%0b %h want %h", got, {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
    endtask

    task automatic test_mute;
        bit got;
        logic [33:0] e;
        drive(8'hFF, 8'hFF, 16'hFFFF, 16'sh7FFF, 16'sh7FFF, 20'hFFFFF, 1'b1);
        wait_valid(300, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
            bad++;
            $display("FAIL mute_sample: got=%0b %h want %h", got, {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
    endtask

    task automatic test_random;
        bit got;
        logic [33:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  20'($urandom_range(0, 20'hFFFFF)), 1'b0);
            wait_valid(300, got);
            e = exp_q.pop_front();
            total++;
            if (!got || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
                bad++;
                $display("FAIL random_sample_%0d: got=%0b %h want %h", i, got,
                         {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        logic [33:0] e;
        drive(8'hFF, 8'h80, 16'h8000, 16'sh0, 16'sh0, 20'h88888, 1'b0);
        wait_valid(300, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
            bad++;
            $display("FAIL pre_reset_sample: got=%0b %h want %h", got, {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
        wait_busy(300, got);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mix.audio_l, mix.audio_r, mix.sample_valid, mix.clip_l, mix.clip_r, mix.busy} !== 36'h0) begin
            bad++;
            $display("FAIL mid_reset_state: got l=%h r=%h v=%b busy=%b want all 0",
                     mix.audio_l, mix.audio_r, mix.sample_valid, mix.busy);
        end
        rst = 1'b0;
        drive(8'hFF, 8'h80, 16'h8000, 16'sh0, 16'sh0, 20'h88888, 1'b0);
        wait_valid(400, got);
        total++;
        if (!got || since != 259) begin
            bad++;
            $display("FAIL post_reset_valid_cycle: got=%0b at %0d want cycle 259", got, since);
        end
        e = exp_q.pop_front();
        total++;
        if ({mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r} !== e) begin
            bad++;
            $display("FAIL post_reset_sample: got %h want %h", {mix.clip_l, mix.clip_r, mix.audio_l, mix.audio_r}, e);
        end
    endtask

    initial begin
        test_reset();
        test_unity_mix();
        test_clip();
        test_snapshot();
        test_mute();
        test_random();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_mix_sequencer.md
Name: audio_mix_sequencer

Overview:
- Mixes the five sound sources of the Williams-2 core into one signed 16-bit stereo sample stream: audio_1, audio_2 (u8 DAC), speech (u16 CVSD), and YM2151 left/right (s16).
- Replaces the free-running per-clock adder tree with a sample-rate scheduler. On each sample tick it snapshots all sources and sequences one shared multiply-accumulate through eight channel slots.
- Applies a 4-bit per-channel gain, then saturates. Sits between williams2 and the emu top-level AUDIO_L/AUDIO_R, with AUDIO_S=1.

Parameters:
- DIV, 250, clock_12 cycles per output sample (12 MHz/250 = 48 kHz); legal range 12..4095.
- ACC_W, 24, accumulator width in bits; must be at least 22.

Ports:
- clock_12  in  1  system clock, 12 MHz
- reset  in  1  synchronous, active-high
- audio_1  in  8  unsigned DAC 1
- audio_2  in  8  unsigned DAC 2
- speech  in  16  unsigned speech sample
- ym2151_left  in  16  signed FM left
- ym2151_right  in  16  signed FM right
- gains  in  20  4-bit gains, packed as [3:0] a1, [7:4] a2, [11:8] speech, [15:12] ym_l, [19:16] ym_r; gain 8 = unity
- mute  in  1  forces output samples to 0
- audio_l  out  16  signed mixed left
- audio_r  out  16  signed mixed right
- sample_valid  out  1  one-cycle pulse when audio_l/audio_r update
- clip_l  out  1  left saturated this sample; valid with sample_valid
- clip_r  out  1  right saturated this sample; valid with sample_valid
- busy  out  1  high while sequencing

Behaviour:
- Reset values: audio_l=0, audio_r=0, sample_valid=0, clip_l=0, clip_r=0, busy=0. Divider counter=0, FSM=IDLE, accumulators=0.
- Divider: counts 0..DIV-1 and wraps. tick=1 when the count is DIV-1. The first tick falls DIV-1 cycles after reset deasserts.
- Source conversion to s16:
  - u8 x becomes {~x[7], x[6:0], 8'h00}, so 0x80 maps to 0.
  - u16 speech becomes {~s[15], s[14:0]}.
  - YM sources pass through unchanged.
- FSM states: IDLE, MAC, SAT.
  - IDLE: when tick occurs in cycle T, register the converted sources, gains and mute. Clear both accumulators, set slot=0, go to MAC. busy=1 from T+1.
  - MAC: one product per cycle, slots 0..7. Order is L:a1, L:a2, L:speech, L:ym_l, R:a1, R:a2, R:speech, R:ym_r, occupying cycles T+1..T+8.
  - Each product is s16 × u4 (gain zero-extended), giving s21. It is sign-extended to ACC_W and added to the accumulator for that slot's side. After slot 7, go to SAT.
  - SAT, cycle T+9: out = acc >>> 3 (arithmetic, floor). Clamp to [-32768, 32767]; the clip flag is set when clamping occurs. If the snapshotted mute is set, the output is 0 and the clip flag is 0.
- Outputs: audio_l, audio_r, clip_l and clip_r are registered. They update, and sample_valid pulses high, in cycle T+10. The FSM is back in IDLE and busy=0 in T+10.
- Fixed latency: tick to sample_valid is 10 cycles. Outputs hold between pulses.
- Snapshot isolation: source, gain or mute changes after cycle T have no effect on the sample in flight.
- Tick while busy cannot occur because DIV>=12. An assertion checks that tick is never seen outside IDLE.
- Reset mid-sequence: all state returns to reset values next cycle and the in-flight sample is discarded (no sample_valid). The divider restarts from 0.
- Unity-gain check: gain 8 with all other gains 0 gives out = source exactly.

Decomposition:
- Package audio_mix_pkg:
  - slot index enum (S_L_A1..S_R_YM)
  - FSM state enum
  - localparams GAIN_UNITY=8, GAIN_SHIFT=3, S16_MAX, S16_MIN
  - conversion functions u8_to_s16 and u16_to_s16
  - sat16 function returning {clip, value}
- One sub-module, audio_mac_sat: a registered-free combinational product plus sign-extend, shared by all slots. Everything else is inline.

Test Plan:
- Reset release, DIV=250: first sample_valid at cycle 259 after reset release (tick at cycle 249, plus 10); the next one 250 cycles later.
- a1=0xFF, a2=0x80, speech=0x8000, ym=0, gains=all 8 -> audio_l=audio_r=0x7F00, no clip.
- ym_l=0x8000, ym_r=0x7FFF, gains ym_l=ym_r=15, others 0 -> audio_l=0x8000 with clip_l=1; audio_r=0x7FFF with clip_r=1.
- ym_l=0x1000, gain 4, others 0 -> audio_l=0x0800, audio_r=0. Change ym_l to 0x7FFF at T+3 -> the in-flight sample is still 0x0800.
- mute=1 at tick with full-scale inputs -> audio_l=audio_r=0, clip flags 0, sample_valid still pulses.
- Reset asserted at T+5 for 1 cycle -> no sample_valid for that tick, outputs 0, busy 0. The next valid comes 259 cycles after reset release.
